border_flash_painter: RTL and testbench

- Next-generation playfield border painter for the breakout VGA pipeline (640x480, BBGGRR 6-bit colour).
- Paints left, right and top borders of parametrised width and position.
- Adds per-side hit-flash: a hit pulse makes that side flash for a programmable number of frames.
- Outputs are registered. They feed the pixel priority mux alongside the ball and brick painters.

---
 rtl/border_flash_painter_if.sv | 31 +++
 rtl/border_flash_painter.sv | 100 ++++++++++
 tb/tb_border_flash_painter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/border_flash_painter_if.sv
`default_nettype none
// ============================================================================
// Module      : border_flash_painter_if
// Description : Pixel-position, frame-tick and hit-pulse bundle feeding the
//               border painter, plus its registered border/colour/flash
//               outputs. The master modport drives positions and pulses; the
//               slave modport is the painter.
// Revision    : 1.0 - initial release
// ============================================================================
interface border_flash_painter_if;
  logic [9:0] hpos;        // current horizontal pixel position
  logic [8:0] vpos;        // current vertical pixel position
  logic       frame_tick;  // one-cycle pulse per frame (start of vblank)
  logic       hit_left;    // one-cycle pulse: ball hit left border
  logic       hit_right;   // one-cycle pulse: ball hit right border
  logic       hit_top;     // one-cycle pulse: ball hit top border
  logic       in_border;   // registered: previous cycle's pixel is border
  logic [5:0] color;       // registered BBGGRR colour, 0 outside the border
  logic [2:0] flashing;    // {top,right,left} flash counter nonzero

  modport master (
    output hpos, vpos, frame_tick, hit_left, hit_right, hit_top,
    input  in_border, color, flashing
  );

  modport slave (
    input  hpos, vpos, frame_tick, hit_left, hit_right, hit_top,
    output in_border, color, flashing
  );
endinterface
`default_nettype wire

// File: rtl/border_flash_painter.sv
`default_nettype none
// ============================================================================
// Module      : border_flash_painter
// Description : Paints the left, right and top playfield borders and makes a
//               side flash for FLASH_FRAMES frames after the ball hits it.
//               Ports:
//                 clk   - pixel clock
//                 reset - synchronous, active-high reset
//                 bus   - slave modport: hpos/vpos/frame_tick/hit_* in,
//                         in_border/color/flashing out (all registered)
// Revision    : 1.0 - initial release
// ============================================================================
module border_flash_painter #(
  parameter int         BORDER_WIDTH = 8,
  parameter logic [9:0] BORDER_LEFT  = 10'd0,
  parameter logic [9:0] BORDER_RIGHT = 10'd632,
  parameter logic [8:0] BORDER_TOP   = 9'd0,
  parameter logic [5:0] BORDER_COLOR = 6'b111111,
  parameter logic [5:0] FLASH_COLOR  = 6'b000011,
  parameter int         FLASH_FRAMES = 8,
  parameter bit         BLINK        = 1'b1
) (
  input  wire                     clk,
  input  wire                     reset,
  border_flash_painter_if.slave   bus
);

  localparam int SHIFT = $clog2(BORDER_WIDTH);
  localparam int CW    = $clog2(FLASH_FRAMES + 1);
  localparam logic [CW-1:0] C_LOAD = CW'(FLASH_FRAMES);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  // Side index order everywhere: 0 = left, 1 = right, 2 = top.
  logic [2:0]         hit;
  logic [2:0]         region;
  logic [2:0]         active;
  logic [2:0][CW-1:0] cnt_q, cnt_d;
  logic [2:0]         flashing_q, flashing_d;
  logic               in_border_q, in_border_d;
  logic [5:0]         color_q, color_d;

  // Borders are aligned to BORDER_WIDTH, so the low position bits never
  // affect the decode.
  logic unused_low_bits;
  assign unused_low_bits = ^{bus.hpos[SHIFT-1:0], bus.vpos[SHIFT-1:0]};

  assign hit = {bus.hit_top, bus.hit_right, bus.hit_left};

  assign region[0] = (bus.hpos[9:SHIFT] == BORDER_LEFT[9:SHIFT]);
  assign region[1] = (bus.hpos[9:SHIFT] == BORDER_RIGHT[9:SHIFT]);
  assign region[2] = (bus.vpos[8:SHIFT] == BORDER_TOP[8:SHIFT]);

  always_comb begin
    cnt_d      = cnt_q;
    flashing_d = '0;
    active     = '0;
    for (int i = 0; i < 3; i++) begin
      // A hit reloads (retrigger, no accumulation) and masks any decrement
      // from a coincident frame tick.
      if (hit[i]) begin
        cnt_d[i] = C_LOAD;
      end else if (bus.frame_tick && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - C_ONE;
      end
      flashing_d[i] = (cnt_d[i] != '0);
      // In blink mode only odd counts show the flash colour, so the colour
      // alternates every frame while the counter runs down.
      active[i] = (cnt_q[i] != '0) && (!BLINK || cnt_q[i][0]);
    end

    in_border_d = |region;
    if (!in_border_d) begin
      color_d = '0;
    end else if (|(region & active)) begin
      color_d = FLASH_COLOR;
    end else begin
      color_d = BORDER_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      flashing_q  <= '0;
      in_border_q <= 1'b0;
      color_q     <= '0;
    end else begin
      cnt_q       <= cnt_d;
      flashing_q  <= flashing_d;
      in_border_q <= in_border_d;
      color_q     <= color_d;
    end
  end

  assign bus.in_border = in_border_q;
  assign bus.color     = color_q;
  assign bus.flashing  = flashing_q;

endmodule
`default_nettype wire

// File: tb/tb_border_flash_painter.sv
`default_nettype none
// ============================================================================
// Module      : tb_border_flash_painter
// Description : Self-checking bench for border_flash_painter. Two painters
//               share the same stimulus, one with solid flashing and one with
//               blinking, and are compared every cycle against a frame-count
//               model of the border and flash rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_border_flash_painter;

  localparam int         W      = 8;
  localparam int         L      = 0;
  localparam int         R      = 632;
  localparam int         T      = 0;
  localparam logic [5:0] BCOL   = 6'b111111;
  localparam logic [5:0] FCOL   = 6'b000011;
  localparam int         FRAMES = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  border_flash_painter_if if0 ();
  border_flash_painter_if if1 ();

  border_flash_painter #(
    .BORDER_WIDTH(W), .BORDER_LEFT(10'd0), .BORDER_RIGHT(10'd632),
    .BORDER_TOP(9'd0), .BORDER_COLOR(BCOL), .FLASH_COLOR(FCOL),
    .FLASH_FRAMES(FRAMES), .BLINK(1'b0)
  ) u_solid (
    .clk(clk), .reset(reset), .bus(if0.slave)
  );

  border_flash_painter #(
    .BORDER_WIDTH(W), .BORDER_LEFT(10'd0), .BORDER_RIGHT(10'd632),
    .BORDER_TOP(9'd0), .BORDER_COLOR(BCOL), .FLASH_COLOR(FCOL),
    .FLASH_FRAMES(FRAMES), .BLINK(1'b1)
  ) u_blink (
    .clk(clk), .reset(reset), .bus(if1.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  // frames[s] = frames of flashing still owed to side s (0=left,1=right,2=top)
  int         frames [3];
  bit         model_valid = 1'b0;
  int         exp_inb;
  int         exp_col [2];
  int         exp_fl;

  always @(posedge clk) begin
    int  h, v;
    bit  in_side [3];
    bit  hitv [3];
    bit  any_in, flash_any;
    h = int'(if0.hpos);
    v = int'(if0.vpos);
    in_side[0] = (h >= L) && (h < L + W);
    in_side[1] = (h >= R) && (h < R + W);
    in_side[2] = (v >= T) && (v < T + W);
    hitv[0] = if0.hit_left;
    hitv[1] = if0.hit_right;
    hitv[2] = if0.hit_top;
    if (reset) begin
      for (int s = 0; s < 3; s++) frames[s] = 0;
      exp_inb    = 0;
      exp_col[0] = 0;
      exp_col[1] = 0;
      exp_fl     = 0;
    end else begin
      any_in  = in_side[0] || in_side[1] || in_side[2];
      exp_inb = any_in ? 1 : 0;
      for (int k = 0; k < 2; k++) begin
        flash_any = 1'b0;
        for (int s = 0; s < 3; s++) begin
          // blinking shows the flash colour on odd remaining-frame counts
          if (in_side[s] && frames[s] > 0 && (k == 0 || (frames[s] % 2) == 1))
            flash_any = 1'b1;
        end
        exp_col[k] = !any_in ? 0 : (flash_any ? int'(FCOL) : int'(BCOL));
      end
      exp_fl = 0;
      for (int s = 0; s < 3; s++) begin
        if (hitv[s]) frames[s] = FRAMES;
        else if (if0.frame_tick && frames[s] > 0) frames[s] = frames[s] - 1;
        if (frames[s] > 0) exp_fl = exp_fl + (1 << s);
      end
    end
    model_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("solid.in_border", int'(if0.in_border), exp_inb);
      check("solid.color",     int'(if0.color),     exp_col[0]);
      check("solid.flashing",  int'(if0.flashing),  exp_fl);
      check("blink.in_border", int'(if1.in_border), exp_inb);
      check("blink.color",     int'(if1.color),     exp_col[1]);
      check("blink.flashing",  int'(if1.flashing),  exp_fl);
    end
  end

  // ------------------------------------------------------------- stimulus
  // Present one pixel (with optional tick/hits) for one cycle; returns 1
  // time unit after the edge, when the registered result for it is visible.
  task automatic drive(input int hh, input int vv, input bit ft,
                       input logic [2:0] hv);
    if0.hpos = 10'(hh); if1.hpos = 10'(hh);
    if0.vpos = 9'(vv);  if1.vpos = 9'(vv);
    if0.frame_tick = ft; if1.frame_tick = ft;
    if0.hit_left  = hv[0]; if1.hit_left  = hv[0];
    if0.hit_right = hv[1]; if1.hit_right = hv[1];
    if0.hit_top   = hv[2]; if1.hit_top   = hv[2];
    @(posedge clk);
    #1;
  endtask

  initial begin
    if0.hpos = '0; if1.hpos = '0;
    if0.vpos = '0; if1.vpos = '0;
    if0.frame_tick = 1'b0; if1.frame_tick = 1'b0;
    if0.hit_left = 1'b0; if1.hit_left = 1'b0;
    if0.hit_right = 1'b0; if1.hit_right = 1'b0;
    if0.hit_top = 1'b0; if1.hit_top = 1'b0;

    reset = 1'b1;
    repeat (3) drive(3, 3, 1'b0, 3'b111);
    check("reset.in_border", int'(if0.in_border), 0);
    check("reset.color",     int'(if0.color), 0);
    check("reset.flashing",  int'(if1.flashing), 0);
    reset = 1'b0;

    // horizontal sweep across the playfield
    for (int h = 0; h < 640; h++) begin
      drive(h, 100, 1'b0, 3'b000);
      if (h == 3)   check("sweep.left_color", int'(if0.color), 6'h3F);
      if (h == 8)   check("sweep.after_left", int'(if0.in_border), 0);
      if (h == 631) check("sweep.before_right", int'(if0.in_border), 0);
      if (h == 632) check("sweep.right_edge", int'(if0.in_border), 1);
    end

    // vertical sweep through the top border
    for (int v = 0; v <= 8; v++) begin
      drive(320, v, 1'b0, 3'b000);
      if (v == 7) check("top.row7_color", int'(if1.color), 6'h3F);
      if (v == 8) check("top.row8_color", int'(if1.color), 0);
    end

    // left hit: solid flashes for 8 frames, blink starts on normal colour
    drive(3, 100, 1'b0, 3'b001);
    drive(3, 100, 1'b0, 3'b000);
    check("left.solid_flash", int'(if0.color), 6'h03);
    check("left.flashing",    int'(if0.flashing), 3'b001);
    check("left.blink_even",  int'(if1.color), 6'h3F);
    for (int t = 1; t <= 8; t++) begin
      drive(3, 100, 1'b1, 3'b000);
      drive(3, 100, 1'b0, 3'b000);
      if (t == 4) begin
        drive(635, 100, 1'b0, 3'b000);
        check("left.right_unaffected", int'(if0.color), 6'h3F);
        drive(320, 2, 1'b0, 3'b000);
        check("left.top_unaffected", int'(if0.color), 6'h3F);
      end
      if (t == 7) check("left.tick7_flash", int'(if0.color), 6'h03);
      if (t == 8) begin
        check("left.tick8_normal", int'(if0.color), 6'h3F);
        check("left.tick8_flashing", int'(if0.flashing), 0);
      end
    end

    // top hit in blink mode: 8 normal, 7 flash, 6 normal ...
    drive(320, 2, 1'b0, 3'b100);
    drive(320, 2, 1'b0, 3'b000);
    check("top.blink_cnt8", int'(if1.color), 6'h3F);
    check("top.solid_cnt8", int'(if0.color), 6'h03);
    for (int t = 1; t <= 8; t++) begin
      drive(320, 2, 1'b1, 3'b000);
      drive(320, 2, 1'b0, 3'b000);
      if (t == 1) check("top.blink_cnt7", int'(if1.color), 6'h03);
      if (t == 2) check("top.blink_cnt6", int'(if1.color), 6'h3F);
      if (t == 7) check("top.blink_cnt1", int'(if1.color), 6'h03);
      if (t == 8) check("top.blink_done", int'(if1.flashing), 0);
    end

    // right hit: coincident tick at 3 loses to the load, re-hit at 5
    drive(635, 100, 1'b0, 3'b010);
    repeat (5) drive(635, 100, 1'b1, 3'b000);
    check("right.model_cnt3", frames[1], 3);
    drive(635, 100, 1'b1, 3'b010);
    check("right.model_load_wins", frames[1], 8);
    repeat (3) drive(635, 100, 1'b1, 3'b000);
    drive(635, 100, 1'b0, 3'b010);
    check("right.model_rehit", frames[1], 8);
    drive(635, 100, 1'b0, 3'b000);
    check("right.blink_cnt8", int'(if1.color), 6'h3F);
    drive(635, 100, 1'b1, 3'b000);
    drive(635, 100, 1'b0, 3'b000);
    check("right.blink_cnt7", int'(if1.color), 6'h03);
    repeat (6) drive(635, 100, 1'b1, 3'b000);
    check("right.still_flashing", int'(if0.flashing), 3'b010);
    drive(635, 100, 1'b1, 3'b000);
    check("right.done", int'(if0.flashing), 0);

    // reset in the middle of a three-sided flash
    drive(0, 0, 1'b0, 3'b111);
    drive(0, 0, 1'b1, 3'b000);
    drive(0, 0, 1'b1, 3'b000);
    check("abort.flashing_before", int'(if0.flashing), 3'b111);
    reset = 1'b1;
    drive(0, 0, 1'b0, 3'b000);
    check("abort.in_border", int'(if1.in_border), 0);
    check("abort.color",     int'(if1.color), 0);
    check("abort.flashing",  int'(if1.flashing), 0);
    reset = 1'b0;
    drive(0, 0, 1'b0, 3'b000);
    check("abort.corner_normal", int'(if0.color), 6'h3F);
    check("abort.corner_blink",  int'(if1.color), 6'h3F);
    drive(635, 2, 1'b1, 3'b000);
    check("abort.no_flash", int'(if0.flashing), 0);
    drive(320, 240, 1'b0, 3'b000);
    drive(320, 240, 1'b0, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
